// File: rtl/joy_pkg.sv
// Shared types and constants for the serial joystick scanner.
package joy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LOAD,
        SHIFT,
        NEXT,
        COMMIT
    } joy_state_t;

    // Bit positions in the decoded active-high button vector
    localparam int JB_RIGHT = 0;
    localparam int JB_LEFT  = 1;
    localparam int JB_DOWN  = 2;
    localparam int JB_UP    = 3;
    localparam int JB_B     = 4;
    localparam int JB_C     = 5;
    localparam int JB_A     = 6;
    localparam int JB_START = 7;

    localparam int JOY_WORD_W = 16;

    // hi: bits 5:0 of a port byte from the SEL=1 pass ({C,B,Up,Down,Left,Right})
    // lo: bits 5:4 of the same port byte from the SEL=0 pass ({Start,A})
    // Chain data is active-low, so every button is inverted here.
    function automatic logic [7:0] joy_decode(input logic [5:0] hi, input logic [1:0] lo);
        logic [7:0] d;
        d           = '0;
        d[JB_RIGHT] = ~hi[0];
        d[JB_LEFT]  = ~hi[1];
        d[JB_DOWN]  = ~hi[2];
        d[JB_UP]    = ~hi[3];
        d[JB_B]     = ~hi[4];
        d[JB_C]     = ~hi[5];
        d[JB_A]     = ~lo[0];
        d[JB_START] = ~lo[1];
        return d;
    endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks.
module joy_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(CLK_DIV - 1));

    // Count 0..CLK_DIV-1 and wrap; tick marks the wrap cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/joy_serial_scanner.sv
// Scans a 16-bit 74HC165 joystick chain in two select passes and
// publishes decoded active-high button vectors atomically.
module joy_serial_scanner #(
    parameter int CLK_DIV      = 25,
    parameter int SETTLE_TICKS = 4,
    parameter int SCAN_TICKS   = 1000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    output logic       JOY_CLK,
    output logic       JOY_LOAD,
    output logic       JOY_SEL,
    input  logic       JOY_DATA,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       joy_strobe
);

    import joy_pkg::*;

    localparam int CNT_MAX = (SCAN_TICKS > SETTLE_TICKS) ? SCAN_TICKS : SETTLE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic                  tick;
    logic [1:0]            data_sync;
    logic                  data_s;
    joy_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [3:0]            bitcnt;
    logic                  phase;
    logic [JOY_WORD_W-1:0] word;
    logic [11:0]           w_hi;   // {port1[5:0], port2[5:0]} from SEL=1 pass
    logic [3:0]            w_lo;   // {port1[5:4], port2[5:4]} from SEL=0 pass
    logic                  unused_bits;

    // Bits 7:6 of each port byte carry nothing
    assign unused_bits = ^{word[15:14], word[7:6]};

    joy_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (CLOCK_50),
        .rst_n(reset_n),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous chain output (idles high)
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            data_sync <= 2'b11;
        end else begin
            data_sync <= {data_sync[0], JOY_DATA};
        end
    end

    assign data_s = data_sync[1];

    // Scan sequencer; tick-paced except NEXT and COMMIT, which take one
    // clock each so the scan period stays an exact multiple of the tick.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            phase      <= 1'b0;
            word       <= '1;
            w_hi       <= '1;
            w_lo       <= '1;
            JOY_CLK    <= 1'b0;
            JOY_LOAD   <= 1'b1;
            JOY_SEL    <= 1'b1;
            joy1       <= 8'h00;
            joy2       <= 8'h00;
            joy_strobe <= 1'b0;
        end else begin
            joy_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        if (cnt == CNT_W'(SCAN_TICKS - 1)) begin
                            cnt     <= '0;
                            JOY_SEL <= 1'b1;
                            state   <= SETTLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (tick) begin
                        if (cnt == CNT_W'(SETTLE_TICKS - 1)) begin
                            cnt      <= '0;
                            JOY_LOAD <= 1'b0;
                            state    <= LOAD;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (tick) begin
                        JOY_LOAD <= 1'b1;
                        bitcnt   <= '0;
                        phase    <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            JOY_CLK <= 1'b0;
                            phase   <= 1'b1;
                        end else begin
                            // Sample before the rising edge takes effect at the chain
                            word[4'(JOY_WORD_W - 1) - bitcnt] <= data_s;
                            JOY_CLK <= 1'b1;
                            phase   <= 1'b0;
                            if (bitcnt == 4'd15) begin
                                state <= NEXT;
                            end else begin
                                bitcnt <= bitcnt + 4'd1;
                            end
                        end
                    end
                end
                NEXT: begin
                    if (JOY_SEL) begin
                        w_hi    <= {word[13:8], word[5:0]};
                        JOY_SEL <= 1'b0;
                        JOY_CLK <= 1'b0;
                        state   <= SETTLE;
                    end else begin
                        w_lo  <= {word[13:12], word[5:4]};
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    joy1       <= joy_decode(w_hi[11:6], w_lo[3:2]);
                    joy2       <= joy_decode(w_hi[5:0], w_lo[1:0]);
                    joy_strobe <= 1'b1;
                    JOY_SEL    <= 1'b1;
                    JOY_CLK    <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joy_serial_scanner.sv
// Directed bench for joy_serial_scanner with a behavioural 74HC165 chain.
module tb_joy_serial_scanner;

    localparam int CLK_DIV  = 25;
    localparam int SETTLE   = 4;
    localparam int SCAN     = 100;
    localparam int SCAN_T   = SCAN + 2 * (SETTLE + 33);
    localparam int PERIOD   = SCAN_T * CLK_DIV;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b1;
    logic       JOY_DATA;
    logic       JOY_CLK, JOY_LOAD, JOY_SEL, joy_strobe;
    logic [7:0] joy1, joy2;

    joy_serial_scanner #(
        .CLK_DIV     (CLK_DIV),
        .SETTLE_TICKS(SETTLE),
        .SCAN_TICKS  (SCAN)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .JOY_CLK   (JOY_CLK),
        .JOY_LOAD  (JOY_LOAD),
        .JOY_SEL   (JOY_SEL),
        .JOY_DATA  (JOY_DATA),
        .joy1      (joy1),
        .joy2      (joy2),
        .joy_strobe(joy_strobe)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Chain model state and monitors
    logic [15:0] w1 = 16'hFFFF, w0 = 16'hFFFF, sr = 16'hFFFF;
    logic        jclk_q = 1'b0, load_q = 1'b1, sel_at_load = 1'b1;
    logic [7:0]  jq1 = 8'h00, jq2 = 8'h00;
    int          cyc = 0, strobe_cnt = 0, rise_cnt = 0, rise_snap = 0;
    int          low_len = 0, load_len = 0, sel_bad = 0, bad_chg = 0;
    int          vectors = 0, miscompares = 0;

    assign JOY_DATA = sr[15];

    // 165 chain (load while low, shift on JOY_CLK rise) plus waveform monitors
    always @(negedge CLOCK_50) begin
        cyc    <= cyc + 1;
        jclk_q <= JOY_CLK;
        load_q <= JOY_LOAD;
        jq1    <= joy1;
        jq2    <= joy2;
        if (joy_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
        if (JOY_LOAD === 1'b0) sr <= (JOY_SEL ? w1 : w0);
        else if (JOY_CLK === 1'b1 && jclk_q === 1'b0) sr <= {sr[14:0], 1'b1};
        if (JOY_LOAD === 1'b0 && load_q === 1'b1) begin
            rise_snap   <= rise_cnt;
            rise_cnt    <= 0;
            sel_at_load <= JOY_SEL;
            low_len     <= 1;
        end else begin
            if (JOY_LOAD === 1'b0) low_len <= low_len + 1;
            if (JOY_CLK === 1'b1 && jclk_q === 1'b0) begin
                rise_cnt <= rise_cnt + 1;
                if (JOY_SEL !== sel_at_load) sel_bad <= sel_bad + 1;
            end
        end
        if (JOY_LOAD === 1'b1 && load_q === 1'b0) load_len <= low_len;
        if (reset_n === 1'b1 && joy_strobe !== 1'b1 && (joy1 !== jq1 || joy2 !== jq2))
            bad_chg <= bad_chg + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic wait_strobe(input string tag, output int at);
        int n;
        n = 0;
        while (joy_strobe !== 1'b1 && n < 3 * PERIOD) begin
            step();
            n++;
        end
        chk({tag, " strobe seen"}, {31'd0, joy_strobe === 1'b1}, 32'd1);
        at = cyc;
    endtask

    initial begin
        int t0, t1, t2, n, sc;

        // Reset
        reset_n = 1'b0;
        repeat (10) step();
        chk("rst JOY_LOAD", {31'd0, JOY_LOAD}, 32'd1);
        chk("rst JOY_SEL", {31'd0, JOY_SEL}, 32'd1);
        chk("rst JOY_CLK", {31'd0, JOY_CLK}, 32'd0);
        chk("rst joy1", {24'd0, joy1}, 32'h00);
        chk("rst joy2", {24'd0, joy2}, 32'h00);
        chk("rst strobe", {31'd0, joy_strobe}, 32'd0);
        chk("rst strobe count", strobe_cnt, 0);

        // Idle chain: all ones both passes
        reset_n = 1'b1;
        t0 = cyc;
        wait_strobe("idle1", t1);
        chk("first scan latency", t1 - t0, PERIOD + 2);
        chk("idle joy1", {24'd0, joy1}, 32'h00);
        chk("idle joy2", {24'd0, joy2}, 32'h00);
        chk("pass1 rises", rise_snap, 16);
        chk("pass2 rises", rise_cnt, 16);
        chk("load low cycles", load_len, CLK_DIV);
        step();
        chk("strobe width", {31'd0, joy_strobe}, 32'd0);
        wait_strobe("idle2", t2);
        chk("scan period", t2 - t1, PERIOD);
        chk("sel stable in pass", sel_bad, 0);

        // Port 1 Up+B, port 2 Start
        step();
        w1 = 16'hE7FF;
        w0 = 16'hFFDF;
        wait_strobe("upb", t1);
        chk("upb joy1", {24'd0, joy1}, 32'h18);
        chk("upb joy2", {24'd0, joy2}, 32'h80);

        // Atomicity: pass-2 data swapped after pass 1 completes
        step();
        w1 = 16'hDEF9;
        w0 = 16'h0000;
        n = 0;
        while (JOY_SEL !== 1'b0 && n < 3 * PERIOD) begin
            step();
            n++;
        end
        chk("atom reached pass2", {31'd0, JOY_SEL === 1'b0}, 32'd1);
        chk("atom joy1 held", {24'd0, joy1}, 32'h18);
        w1 = 16'h0000;
        w0 = 16'hEFFF;
        wait_strobe("atom", t1);
        chk("atom joy1", {24'd0, joy1}, 32'h61);
        chk("atom joy2", {24'd0, joy2}, 32'h06);
        chk("no change off strobe", bad_chg, 0);

        // Reset in the middle of pass-2 shifting
        step();
        w1 = 16'hFFFE;
        w0 = 16'hEFFF;
        n = 0;
        while (!(JOY_SEL === 1'b0 && JOY_LOAD === 1'b1 && rise_cnt == 7) && n < 3 * PERIOD) begin
            step();
            n++;
        end
        chk("midrst reached bit7", {31'd0, JOY_SEL === 1'b0 && rise_cnt == 7}, 32'd1);
        sc = strobe_cnt;
        reset_n = 1'b0;
        step();
        chk("midrst joy1", {24'd0, joy1}, 32'h00);
        chk("midrst joy2", {24'd0, joy2}, 32'h00);
        chk("midrst strobe", {31'd0, joy_strobe}, 32'd0);
        chk("midrst JOY_SEL", {31'd0, JOY_SEL}, 32'd1);
        chk("midrst JOY_CLK", {31'd0, JOY_CLK}, 32'd0);
        chk("midrst JOY_LOAD", {31'd0, JOY_LOAD}, 32'd1);
        repeat (5) step();
        reset_n = 1'b1;
        t0 = cyc;
        chk("midrst no strobe", strobe_cnt, sc);
        wait_strobe("post", t1);
        chk("post latency", t1 - t0, PERIOD + 2);
        chk("post joy1", {24'd0, joy1}, 32'h40);
        chk("post joy2", {24'd0, joy2}, 32'h01);
        chk("post sel stable", sel_bad, 0);
        chk("post no change off strobe", bad_chg, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
